// File: rtl/nn_pkg.sv
// Shared types, widths and helpers for the dense matmul stages.
// Holds the Q16.16 format constants, FSM state enum and sat32().
package nn_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int FRAC_BITS = 16;
    localparam int SAT_ACC_W = 72;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Scale a wide Q32.32 sum back to Q16.16 and clamp.
    // The shift floors toward -inf; the value fits in 32 bits
    // only when bits [71:31] are all copies of the sign.
    function automatic logic [DATA_W-1:0] sat32(
        input logic signed [SAT_ACC_W-1:0] acc
    );
        logic signed [SAT_ACC_W-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (!sh[SAT_ACC_W-1] && (|sh[SAT_ACC_W-2:DATA_W-1]))
            return 32'h7FFF_FFFF;
        else if (sh[SAT_ACC_W-1] && !(&sh[SAT_ACC_W-2:DATA_W-1]))
            return 32'h8000_0000;
        else
            return sh[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mac_acc.sv
// Signed 32x32 multiply-accumulate with clear and Q16.16 saturated result.
// Ports: clk, rst, en (accumulate), clr (zero acc), a, b, result.
module mac_acc
    import nn_pkg::*;
#(
    parameter int ACC_WIDTH = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_WIDTH-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

    // Sign-extend to the helper's fixed width before shifting.
    assign result = sat32(SAT_ACC_W'(acc));

endmodule

// File: rtl/matmul3_unit.sv
// Layer-3 dense stage: out[j] = sat32(sum_i relu2[i]*W3[i][j] >>> 16).
// Ports: clk, rst, start, relu2/weight read ports, out write port, busy, done.
module matmul3_unit
    import nn_pkg::*;
#(
    parameter int IN_SIZE   = 64,
    parameter int OUT_SIZE  = 10,
    parameter int ACC_WIDTH = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] relu2_read_addr,
    input  logic [DATA_W-1:0] relu2_data,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight_data,
    output logic [ADDR_W-1:0] out_write_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_write_enable,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] waddr;
    logic              i_last;
    logic              j_last;
    logic              mac_en;
    logic              acc_clr;
    logic [DATA_W-1:0] result;

    assign i_last = (i == ADDR_W'(IN_SIZE - 1));
    assign j_last = (j == ADDR_W'(OUT_SIZE - 1));

    mac_acc #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clr   (acc_clr),
        .a     (relu2_data),
        .b     (weight_data),
        .result(result)
    );

    always_comb begin
        state_n = state;
        mac_en  = 1'b0;
        acc_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (i_last)
                    state_n = WRITE;
            end
            WRITE: begin
                acc_clr = 1'b1;
                state_n = j_last ? DONE : MAC;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // waddr tracks i*OUT_SIZE+j by stepping a row per MAC
    // and reloading the next column base after each write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            waddr <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    i     <= '0;
                    j     <= '0;
                    waddr <= '0;
                end
                MAC: begin
                    i     <= i + 1'b1;
                    waddr <= waddr + ADDR_W'(OUT_SIZE);
                end
                WRITE: begin
                    i     <= '0;
                    j     <= j + 1'b1;
                    waddr <= j + 1'b1;
                end
                DONE: begin
                    j     <= '0;
                    waddr <= '0;
                end
                default: begin
                    i     <= '0;
                    j     <= '0;
                    waddr <= '0;
                end
            endcase
        end
    end

    always_comb begin
        relu2_read_addr  = '0;
        weight_addr      = '0;
        out_write_addr   = '0;
        out_data         = '0;
        out_write_enable = 1'b0;
        if (state == MAC) begin
            relu2_read_addr = i;
            weight_addr     = waddr;
        end
        if (state == WRITE) begin
            out_write_enable = 1'b1;
            out_write_addr   = j;
            out_data         = result;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_matmul3_unit.sv
// Directed bench for matmul3_unit with behavioural input/weight/output memories.
// Checks reset state, results, write order, latency, saturation, truncation, restart and reset.
module tb_matmul3_unit;

    localparam int NI = 64;
    localparam int NO = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] relu2_read_addr;
    logic [31:0] relu2_data;
    logic [15:0] weight_addr;
    logic [31:0] weight_data;
    logic [15:0] out_write_addr;
    logic [31:0] out_data;
    logic        out_write_enable;
    logic        busy;
    logic        done;

    logic [31:0] relu2_mem [NI];
    logic [31:0] w_mem [NI*NO];
    logic [31:0] out_mem [NO];
    int          wr_log [64];
    int          wr_n = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          d0;

    always #5 clk = ~clk;

    matmul3_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .relu2_read_addr (relu2_read_addr),
        .relu2_data      (relu2_data),
        .weight_addr     (weight_addr),
        .weight_data     (weight_data),
        .out_write_addr  (out_write_addr),
        .out_data        (out_data),
        .out_write_enable(out_write_enable),
        .busy            (busy),
        .done            (done)
    );

    assign relu2_data  = relu2_mem[relu2_read_addr[5:0]];
    assign weight_data = (weight_addr < 16'(NI*NO)) ? w_mem[weight_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (out_write_enable && out_write_addr < 16'(NO))
            out_mem[out_write_addr[3:0]] = out_data;
    end

    always @(negedge clk) begin
        if (out_write_enable) begin
            if (wr_n < 64)
                wr_log[wr_n] = int'(out_write_addr);
            wr_n = wr_n + 1;
        end
        if (done)
            done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] r, input logic [31:0] w);
        for (int k = 0; k < NI; k++) relu2_mem[k] = r;
        for (int k = 0; k < NI*NO; k++) w_mem[k] = w;
    endtask

    task automatic clear_out();
        for (int k = 0; k < NO; k++) out_mem[k] = 32'hDEAD_BEEF;
        wr_n = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_we"}, 32'(out_write_enable), 32'h0);
        chk({tag, "_raddr"}, 32'(relu2_read_addr), 32'h0);
        chk({tag, "_waddr"}, 32'(weight_addr), 32'h0);
        chk({tag, "_oaddr"}, 32'(out_write_addr), 32'h0);
        chk({tag, "_odata"}, 32'(out_data), 32'h0);
    endtask

    // lat = cycles from the start-sampling edge to the edge opening the
    // done cycle; -1 if done never appears within the budget.
    task automatic run_pass(input int repulse, input int rst_at, output int l);
        l = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (done) begin
                l = n;
                break;
            end
            if (n == 10) chk("busy_mid", 32'(busy), 32'h1);
            if (n == repulse) start = 1'b1;
            if (n == repulse + 1) start = 1'b0;
            if (n == rst_at) rst = 1'b1;
            if (n == rst_at + 1) rst = 1'b0;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic full_pass(input string tag, input int repulse,
                             input logic [31:0] e0, input logic [31:0] step);
        clear_out();
        d0 = done_cnt;
        run_pass(repulse, -1, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd650);
        @(negedge clk);
        chk({tag, "_done_len"}, 32'(done), 32'h0);
        chk({tag, "_busy_after"}, 32'(busy), 32'h0);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_writes"}, 32'(wr_n), 32'(NO));
        for (int k = 0; k < NO; k++) begin
            chk($sformatf("%s_order%0d", tag, k), 32'(wr_log[k]), 32'(k));
            chk($sformatf("%s_out%0d", tag, k), out_mem[k], e0 + step * 32'(k));
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) wr_log[k] = -1;
        fill(32'h0, 32'h0);
        clear_out();

        // 1. reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_rel");

        // 2. all ones: 64 * 1.0 = 64.0
        fill(32'h0001_0000, 32'h0001_0000);
        full_pass("ones", -1, 32'h0040_0000, 32'h0);

        // 3. identity weights pick relu2[j]
        for (int k = 0; k < NI; k++) relu2_mem[k] = k << 16;
        for (int r = 0; r < NI; r++)
            for (int c = 0; c < NO; c++)
                w_mem[r*NO + c] = (r == c) ? 32'h0001_0000 : 32'h0;
        full_pass("ident", -1, 32'h0, 32'h0001_0000);

        // 4. saturation both ways
        fill(32'h7FFF_0000, 32'h7FFF_0000);
        full_pass("satpos", -1, 32'h7FFF_FFFF, 32'h0);
        fill(32'h7FFF_0000, 32'h8001_0000);
        full_pass("satneg", -1, 32'h8000_0000, 32'h0);

        // 5. truncation toward -inf
        fill(32'h0, 32'h0000_0001);
        relu2_mem[0] = 32'hFFFF_FFFF;
        full_pass("truncneg", -1, 32'hFFFF_FFFF, 32'h0);
        relu2_mem[0] = 32'h0000_0001;
        full_pass("truncpos", -1, 32'h0, 32'h0);

        // 6a. start while busy is ignored
        fill(32'h0001_0000, 32'h0001_0000);
        full_pass("repulse", 50, 32'h0040_0000, 32'h0);

        // 6b. reset mid-pass: j=0 already written, nothing after
        clear_out();
        d0 = done_cnt;
        run_pass(-1, 100, lat);
        chk("rst_mid_nodone", 32'(lat), 32'hFFFF_FFFF);
        chk("rst_mid_pulses", 32'(done_cnt - d0), 32'h0);
        chk("rst_mid_writes", 32'(wr_n), 32'h1);
        chk("rst_mid_out0", out_mem[0], 32'h0040_0000);
        chk("rst_mid_out1", out_mem[1], 32'hDEAD_BEEF);
        check_idle("rst_mid");

        full_pass("fresh", -1, 32'h0040_0000, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
